// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch stage.
// Holds the architectural PC and fetches from instruction memory with a
// request/acknowledge handshake. It captures the returned word for decode,
// flags fetch timeouts and misaligned next-PC values, and counts retired
// instructions.
//
// Handshake: IMemReq is high in every FETCH cycle, and IMemAddr stays stable
// for that whole interval. A fetch completes on the first cycle in which
// IMemAck is sampled high while in FETCH. An IMemAck seen in any other state
// is dropped. Advance is a one-cycle retire strobe, and it only takes effect
// while InstrValid is high.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        ResetL,
    input  logic [63:0] NextPC,
    input  logic        Advance,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [63:0] CurrentPC,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        FetchError,
    output logic [31:0] InstrCount,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    // The last FETCH cycle that may still receive an ack before a timeout.
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [31:0] count;

    // FSM: sequence IDLE -> FETCH <-> VALID, with ERROR as a sticky sink.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    // An ack in the limit cycle wins over the timeout.
                    if (IMemAck)
                        state <= VALID;
                    else if (wait_cnt == WAIT_LIMIT)
                        state <= ERROR;
                end
                VALID: begin
                    if (Advance)
                        state <= (NextPC[1:0] == 2'b00) ? FETCH : ERROR;
                end
                default: state <= ERROR;
            endcase
        end
    end

    // Wait counter: counts FETCH cycles that pass without an ack. It is
    // cleared on a completed fetch, so each new fetch starts from zero.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            wait_cnt <= 8'd0;
        end else if (state == FETCH) begin
            if (IMemAck)
                wait_cnt <= 8'd0;
            else if (wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Instruction capture: only the ack received during FETCH is used.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL)
            instr <= 32'd0;
        else if (state == FETCH && IMemAck)
            instr <= IMemData;
    end

    // PC and retire counter. A misaligned NextPC is still loaded so that it
    // can be inspected after the error, but it does not count as a retire.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            pc    <= RESET_PC;
            count <= 32'd0;
        end else if (state == VALID && Advance) begin
            pc <= NextPC;
            if (NextPC[1:0] == 2'b00)
                count <= count + 32'd1;
        end
    end

    // Outputs are decoded from registered state only.
    assign IMemReq     = (state == FETCH);
    assign IMemAddr    = pc;
    assign CurrentPC   = pc;
    assign Instruction = instr;
    assign InstrValid  = (state == VALID);
    assign FetchError  = (state == ERROR);
    assign InstrCount  = count;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit, with RESET_PC=0x100
// and MAX_WAIT=4.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        ResetL;
    logic [63:0] NextPC;
    logic        Advance;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        FetchError;
    logic [31:0] InstrCount;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    int n_cmp;
    int n_err;

    fetch_pc_unit #(.RESET_PC(64'h100), .MAX_WAIT(4)) dut (
        .CLK(CLK),
        .ResetL(ResetL),
        .NextPC(NextPC),
        .Advance(Advance),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemAck(IMemAck),
        .IMemData(IMemData),
        .CurrentPC(CurrentPC),
        .Instruction(Instruction),
        .InstrValid(InstrValid),
        .FetchError(FetchError),
        .InstrCount(InstrCount),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog: stop a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Compare the captured instruction against the oldest queued word.
    task automatic pop_instr(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, 64'(InstrValid), 64'h1);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 64'(Instruction), 64'(e));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   64'(IMemReq),     64'h0);
        chk({tag, "_valid"}, 64'(InstrValid),  64'h0);
        chk({tag, "_err"},   64'(FetchError),  64'h0);
        chk({tag, "_pc"},    CurrentPC,        64'h100);
        chk({tag, "_instr"}, 64'(Instruction), 64'h0);
        chk({tag, "_count"}, 64'(InstrCount),  64'h0);
        chk({tag, "_state"}, 64'(dbg_state),   64'h0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        ResetL   = 1'b0;
        NextPC   = 64'h0;
        Advance  = 1'b0;
        IMemAck  = 1'b0;
        IMemData = 32'h0;

        // Power-on reset state.
        repeat (2) @(posedge CLK);
        #1;
        check_reset("por");

        // Release reset; the first edge moves IDLE -> FETCH.
        ResetL = 1'b1;
        step();
        chk("first_req", 64'(IMemReq), 64'h1);
        chk("first_addr", IMemAddr, 64'h100);
        chk("first_state", 64'(dbg_state), 64'h1);
        IMemAck  = 1'b1;
        IMemData = 32'h8B020020;
        exp_q.push_back(IMemData);
        step();
        IMemAck = 1'b0;
        pop_instr("first_instr");
        chk("first_count", 64'(InstrCount), 64'h0);
        chk("first_req_low", 64'(IMemReq), 64'h0);

        // A stray ack in VALID must not overwrite the instruction.
        IMemAck  = 1'b1;
        IMemData = 32'hDEADBEEF;
        step();
        IMemAck = 1'b0;
        chk("stray_ack_instr", 64'(Instruction), 64'h8B020020);
        chk("stray_ack_valid", 64'(InstrValid), 64'h1);

        // Sequential retire to 0x104.
        Advance = 1'b1;
        NextPC  = 64'h104;
        step();
        Advance = 1'b0;
        chk("retire1_pc", CurrentPC, 64'h104);
        chk("retire1_req", 64'(IMemReq), 64'h1);
        chk("retire1_valid", 64'(InstrValid), 64'h0);
        chk("retire1_count", 64'(InstrCount), 64'h1);

        // Advance during FETCH is ignored.
        Advance = 1'b1;
        NextPC  = 64'h200;
        step();
        Advance = 1'b0;
        chk("fetch_adv_pc", CurrentPC, 64'h104);
        chk("fetch_adv_count", 64'(InstrCount), 64'h1);
        chk("fetch_adv_req", 64'(IMemReq), 64'h1);
        IMemAck  = 1'b1;
        IMemData = 32'h91000421;
        exp_q.push_back(IMemData);
        step();
        IMemAck = 1'b0;
        pop_instr("second_instr");

        // Branch retire to 0x40.
        Advance = 1'b1;
        NextPC  = 64'h40;
        step();
        Advance = 1'b0;
        chk("branch_addr", IMemAddr, 64'h40);
        chk("branch_count", 64'(InstrCount), 64'h2);

        // Ack on the 4th and final allowed FETCH cycle.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("late_req%0d", i), 64'(IMemReq), 64'h1);
            step();
        end
        IMemAck  = 1'b1;
        IMemData = 32'hF9400041;
        exp_q.push_back(IMemData);
        step();
        IMemAck = 1'b0;
        pop_instr("late_ack_instr");
        chk("late_ack_err", 64'(FetchError), 64'h0);

        // A misaligned NextPC raises the error without counting a retire.
        Advance = 1'b1;
        NextPC  = 64'h102;
        step();
        Advance = 1'b0;
        chk("misalign_err", 64'(FetchError), 64'h1);
        chk("misalign_pc", CurrentPC, 64'h102);
        chk("misalign_count", 64'(InstrCount), 64'h2);
        chk("misalign_req", 64'(IMemReq), 64'h0);
        chk("misalign_valid", 64'(InstrValid), 64'h0);

        // Asynchronous reset out of ERROR, then a fetch that times out.
        ResetL = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge CLK);
        #1;
        ResetL = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("timeout_req%0d", i), 64'(IMemReq), 64'h1);
            step();
        end
        chk("timeout_err", 64'(FetchError), 64'h1);
        chk("timeout_req_low", 64'(IMemReq), 64'h0);
        IMemAck  = 1'b1;
        IMemData = 32'h12345678;
        Advance  = 1'b1;
        NextPC   = 64'h8;
        step();
        step();
        IMemAck = 1'b0;
        Advance = 1'b0;
        chk("sticky_err", 64'(FetchError), 64'h1);
        chk("sticky_pc", CurrentPC, 64'h100);
        chk("sticky_count", 64'(InstrCount), 64'h0);
        chk("sticky_instr", 64'(Instruction), 64'h0);
        chk("sticky_valid", 64'(InstrValid), 64'h0);

        // Reset pulsed mid-FETCH; an ack held through reset release is ignored.
        ResetL = 1'b0;
        @(posedge CLK);
        #1;
        ResetL = 1'b1;
        step();
        step();
        chk("midfetch_req", 64'(IMemReq), 64'h1);
        ResetL = 1'b0;
        #1;
        check_reset("midfetch_reset");
        IMemAck  = 1'b1;
        IMemData = 32'hCAFEF00D;
        @(posedge CLK);
        #1;
        ResetL = 1'b1;
        step();
        IMemAck = 1'b0;
        chk("late_ack_ignored_valid", 64'(InstrValid), 64'h0);
        chk("late_ack_ignored_instr", 64'(Instruction), 64'h0);
        chk("late_ack_ignored_req", 64'(IMemReq), 64'h1);

        // A normal fetch still works after recovery.
        IMemAck  = 1'b1;
        IMemData = 32'hD503201F;
        exp_q.push_back(IMemData);
        step();
        IMemAck = 1'b0;
        pop_instr("recover_instr");
        chk("recover_pc", CurrentPC, 64'h100);

        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
